// File: rtl/dmem_wbuf_if.sv
// Memory-stage access bundle between the MIPS core and the data-memory
// write-buffer block. The core drives requests and the block returns load
// data plus buffer status.
interface dmem_wbuf_if #(
  parameter int WB_DEPTH = 4
);
  localparam int CW = $clog2(WB_DEPTH) + 1;

  logic          MemRead_M;
  logic          MemWrite_M;
  logic [31:0]   ALUResult_M;
  logic [31:0]   WriteData_M;
  logic          fence;
  logic [31:0]   ReadData_M;
  logic [CW-1:0] wb_count;
  logic          wb_full;
  logic          wb_empty;
  logic          acc_err;

  modport master (
    output MemRead_M, MemWrite_M, ALUResult_M, WriteData_M, fence,
    input  ReadData_M, wb_count, wb_full, wb_empty, acc_err
  );

  modport slave (
    input  MemRead_M, MemWrite_M, ALUResult_M, WriteData_M, fence,
    output ReadData_M, wb_count, wb_full, wb_empty, acc_err
  );
endinterface

// File: rtl/dmem_wbuf.sv
// Data memory with a posted-store write buffer. Stores are queued and drained
// into a single-port word array on cycles without a load; loads forward from
// the youngest matching buffered store so the core never stalls.
module dmem_wbuf #(
  parameter int ADDR_W   = 8,
  parameter int WB_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  dmem_wbuf_if.slave bus
);
  localparam int PW    = $clog2(WB_DEPTH);
  localparam int CW    = PW + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  // Buffer state; wb_count_r alone decides full/empty, pointers only index.
  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [CW-1:0]     count_r;
  logic              full_r;
  logic              empty_r;
  logic              acc_err_r;
  logic [ADDR_W-1:0] wb_idx_r  [WB_DEPTH];
  logic [31:0]       wb_data_r [WB_DEPTH];
  logic [31:0]       mem_r     [DEPTH];

  logic [ADDR_W-1:0] idx_s;
  logic              misaligned_s;
  logic              load_s;
  logic              store_s;
  logic              drain_s;
  logic              nonempty_s;
  logic              err_s;
  logic [CW-1:0]     count_nxt_s;
  logic              fwd_hit_s;
  logic [31:0]       fwd_data_s;
  logic [31:0]       rdata_s;
  logic              unused_addr_s;

  // Upper address bits alias onto the array and are intentionally ignored.
  assign unused_addr_s = &{1'b0, bus.ALUResult_M[31:ADDR_W+2]};

  // Decode the access and decide enqueue, drain and error for this cycle.
  always_comb begin
    idx_s        = bus.ALUResult_M[ADDR_W+1:2];
    misaligned_s = (bus.ALUResult_M[1:0] != 2'b00);
    load_s       = bus.MemRead_M & ~misaligned_s;
    // A store only counts when it is alone on the bus and aligned.
    store_s      = bus.MemWrite_M & ~bus.MemRead_M & ~misaligned_s;
    nonempty_s   = (count_r != {CW{1'b0}});
    // Any read request owns the array port; a discarded store looks idle.
    drain_s      = nonempty_s & ~bus.MemRead_M & (~store_s | bus.fence | full_r);
    err_s        = (bus.MemRead_M & bus.MemWrite_M) |
                   ((bus.MemRead_M | bus.MemWrite_M) & misaligned_s);
    case ({store_s, drain_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Youngest-match forwarding: walk oldest to youngest, later hits override.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'h0000_0000;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if ((CW'(k) < count_r) && (wb_idx_r[head_r + PW'(k)] == idx_s)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = wb_data_r[head_r + PW'(k)];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Same-cycle load data: buffer hit first, then the array, zero otherwise.
  always_comb begin
    if (load_s) begin
      if (fwd_hit_s) begin
        rdata_s = fwd_data_s;
      end else begin
        rdata_s = mem_r[idx_s];
      end
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Buffer pointers, occupancy, status flags and the error pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head_r    <= {PW{1'b0}};
      tail_r    <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      acc_err_r <= 1'b0;
      for (int k = 0; k < WB_DEPTH; k++) begin
        wb_idx_r[k]  <= {ADDR_W{1'b0}};
        wb_data_r[k] <= 32'h0000_0000;
      end
    end else begin
      if (store_s) begin
        wb_idx_r[tail_r]  <= idx_s;
        wb_data_r[tail_r] <= bus.WriteData_M;
        tail_r            <= tail_r + PW'(1);
      end
      if (drain_s) begin
        head_r <= head_r + PW'(1);
      end
      count_r   <= count_nxt_s;
      full_r    <= (count_nxt_s == CW'(WB_DEPTH));
      empty_r   <= (count_nxt_s == {CW{1'b0}});
      acc_err_r <= err_s;
    end
  end

  // Single array write port, fed only by the oldest buffer entry on a drain.
  always_ff @(posedge CLK) begin
    if (drain_s) begin
      mem_r[wb_idx_r[head_r]] <= wb_data_r[head_r];
    end
  end

  assign bus.ReadData_M = rdata_s;
  assign bus.wb_count   = count_r;
  assign bus.wb_full    = full_r;
  assign bus.wb_empty   = empty_r;
  assign bus.acc_err    = acc_err_r;
endmodule

// File: tb/tb_dmem_wbuf.sv
// Self-checking bench for dmem_wbuf: load data expectations are queued when a
// load is driven and popped when the combinational output is sampled.
module tb_dmem_wbuf;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_d;
  logic [2:0]  exp_c;

  always #5 clk = ~clk;

  dmem_wbuf_if bus ();
  dmem_wbuf dut (.CLK(clk), .RST(rst_n), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic fen);
    bus.MemRead_M   = rd;
    bus.MemWrite_M  = wr;
    bus.ALUResult_M = addr;
    bus.WriteData_M = data;
    bus.fence       = fen;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #12;
    checks++; if (bus.wb_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.wb_count); end
    checks++; if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", bus.wb_empty); end
    checks++; if (bus.wb_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", bus.wb_full); end
    checks++; if (bus.acc_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.acc_err); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forward();
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    tick();
    checks++; if (bus.wb_count !== 3'd1) begin errors++; $display("FAIL fwd_count1 got %0d exp 1", bus.wb_count); end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL fwd_data got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
    checks++; if (bus.wb_count !== 3'd1) begin errors++; $display("FAIL fwd_count_load got %0d exp 1", bus.wb_count); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    checks++; if (bus.wb_count !== 3'd0) begin errors++; $display("FAIL fwd_count_drain got %0d exp 0", bus.wb_count); end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL fwd_array got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
      tick();
    end
    checks++; if (bus.wb_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", bus.wb_full); end
    checks++; if (bus.wb_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", bus.wb_count); end
    drive(1'b0, 1'b1, 32'h10, 32'hE4, 1'b0);
    tick();
    checks++; if (bus.wb_count !== 3'd4) begin errors++; $display("FAIL full_store_count got %0d exp 4", bus.wb_count); end
    checks++; if (bus.wb_full !== 1'b1) begin errors++; $display("FAIL full_store_flag got %b exp 1", bus.wb_full); end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_q.push_back(32'hA0);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL full_ld0 got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    exp_q.push_back(32'hE4);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL full_ld10 got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
    drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    exp_q.push_back(32'hA2);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL full_ld8 got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
    checks++; if (bus.wb_count !== 3'd4) begin errors++; $display("FAIL full_load_count got %0d exp 4", bus.wb_count); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_c = 3'(3 - i);
      checks++; if (bus.wb_count !== exp_c) begin errors++; $display("FAIL full_drain_count got %0d exp %0d", bus.wb_count, exp_c); end
    end
    checks++; if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %b exp 1", bus.wb_empty); end
    drive(1'b1, 1'b0, 32'hC, 32'h0, 1'b0);
    exp_q.push_back(32'hA3);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL full_ldC got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 32'h20, 32'h1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h20, 32'h2, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    exp_q.push_back(32'h2);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL b2b_youngest got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
    checks++; if (bus.wb_count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", bus.wb_count); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    checks++; if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", bus.wb_empty); end
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    exp_q.push_back(32'h2);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL b2b_array got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
  endtask

  task automatic test_misaligned();
    drive(1'b0, 1'b1, 32'h40, 32'h77, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h22, 32'h0, 1'b0);
    exp_q.push_back(32'h0);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL mis_data got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
    checks++; if (bus.acc_err !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", bus.acc_err); end
    checks++; if (bus.wb_count !== 3'd1) begin errors++; $display("FAIL mis_count got %0d exp 1", bus.wb_count); end
    drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    exp_q.push_back(32'h77);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL mis_fwd got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
    checks++; if (bus.acc_err !== 1'b0) begin errors++; $display("FAIL mis_err_clear got %b exp 0", bus.acc_err); end
    // Misaligned store alone behaves as an idle cycle: drains, no enqueue.
    drive(1'b0, 1'b1, 32'h41, 32'hBAD, 1'b0);
    tick();
    checks++; if (bus.wb_count !== 3'd0) begin errors++; $display("FAIL mis_wr_count got %0d exp 0", bus.wb_count); end
    checks++; if (bus.acc_err !== 1'b1) begin errors++; $display("FAIL mis_wr_err got %b exp 1", bus.acc_err); end
    drive(1'b1, 1'b0, 32'h23, 32'h0, 1'b0);
    tick();
    checks++; if (bus.acc_err !== 1'b1) begin errors++; $display("FAIL mis_err_held got %b exp 1", bus.acc_err); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    checks++; if (bus.acc_err !== 1'b0) begin errors++; $display("FAIL mis_err_end got %b exp 0", bus.acc_err); end
  endtask

  task automatic test_rw_conflict();
    drive(1'b0, 1'b1, 32'h30, 32'h1234, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h34, 32'h99, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h30, 32'h55, 1'b0);
    exp_q.push_back(32'h1234);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL rw_data got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
    checks++; if (bus.acc_err !== 1'b1) begin errors++; $display("FAIL rw_err got %b exp 1", bus.acc_err); end
    checks++; if (bus.wb_count !== 3'd1) begin errors++; $display("FAIL rw_count got %0d exp 1", bus.wb_count); end
    drive(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
    exp_q.push_back(32'h1234);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL rw_prior got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
    checks++; if (bus.acc_err !== 1'b0) begin errors++; $display("FAIL rw_err_clear got %b exp 0", bus.acc_err); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_fence();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h50 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
      tick();
    end
    checks++; if (bus.wb_count !== 3'd3) begin errors++; $display("FAIL fence_fill got %0d exp 3", bus.wb_count); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h54, 32'h0, 1'b1);
      exp_q.push_back(32'hC1);
      @(negedge clk); exp_d = exp_q.pop_front();
      checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL fence_ld got %h exp %h", bus.ReadData_M, exp_d); end
      tick();
      checks++; if (bus.wb_count !== 3'd3) begin errors++; $display("FAIL fence_hold got %0d exp 3", bus.wb_count); end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_c = 3'(2 - i);
      checks++; if (bus.wb_count !== exp_c) begin errors++; $display("FAIL fence_drain got %0d exp %0d", bus.wb_count, exp_c); end
    end
    drive(1'b0, 1'b1, 32'h60, 32'hD0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h64, 32'hD1, 1'b1);
    tick();
    checks++; if (bus.wb_count !== 3'd1) begin errors++; $display("FAIL fence_store got %0d exp 1", bus.wb_count); end
    drive(1'b1, 1'b0, 32'h60, 32'h0, 1'b0);
    exp_q.push_back(32'hD0);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL fence_arr got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
    drive(1'b1, 1'b0, 32'h64, 32'h0, 1'b0);
    exp_q.push_back(32'hD1);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL fence_fwd got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h70 + 32'(4 * i), 32'hE0 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    checks++; if (bus.wb_count !== 3'd2) begin errors++; $display("FAIL mid_count got %0d exp 2", bus.wb_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.wb_count !== 3'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", bus.wb_count); end
    checks++; if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got %b exp 1", bus.wb_empty); end
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h70, 32'h0, 1'b0);
    exp_q.push_back(32'hE0);
    @(negedge clk); exp_d = exp_q.pop_front();
    checks++; if (bus.ReadData_M !== exp_d) begin errors++; $display("FAIL mid_kept got %h exp %h", bus.ReadData_M, exp_d); end
    tick();
    checks++; if (bus.wb_count !== 3'd0) begin errors++; $display("FAIL mid_after got %0d exp 0", bus.wb_count); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_full();
    test_back_to_back();
    test_misaligned();
    test_rw_conflict();
    test_fence();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
Data-memory block directly downstream of the pipelined MIPS core's memory stage. It consumes the core's memory-stage access (MemRead_M, MemWrite_M, ALUResult_M, WriteData_M) and produces ReadData_M. Stores are posted into a small write buffer and drained into a single-port word array during cycles with no load. Loads see buffered stores through youngest-match forwarding, so the core never stalls on memory.

Parameters:
ADDR_W, 8, word-index width; the array holds 2^ADDR_W 32-bit words.
WB_DEPTH, 4, write-buffer entries; must be a power of two and at least 2.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  reset, asynchronous, active-low.
MemRead_M  input  1  load request this cycle.
MemWrite_M  input  1  store request this cycle.
ALUResult_M  input  32  byte address.
WriteData_M  input  32  store data.
fence  input  1  force drain whenever the array port is free.
ReadData_M  output  32  load data, combinational.
wb_count  output  $clog2(WB_DEPTH)+1  occupied buffer entries.
wb_full  output  1  wb_count == WB_DEPTH.
wb_empty  output  1  wb_count == 0.
acc_err  output  1  registered one-cycle error pulse.

Behaviour:
- Reset (RST low, asynchronous): head=0, tail=0, wb_count=0, wb_empty=1, wb_full=0, acc_err=0. Array contents are not reset and are undefined until written.
- Address decode: idx = ALUResult_M[ADDR_W+1:2]. Bits above ADDR_W+1 are ignored (aliasing). misaligned = ALUResult_M[1:0] != 0.
- Load (MemRead_M=1, aligned):
  - ReadData_M is the data of the youngest valid buffer entry whose idx matches, otherwise array[idx].
  - Zero added latency; the value is valid in the same cycle.
- ReadData_M = 0 when MemRead_M=0 or the address is misaligned.
- Store (MemWrite_M=1, MemRead_M=0, aligned):
  - {idx, WriteData_M} is written at tail on the rising edge; tail increments modulo WB_DEPTH.
  - Duplicate indices are allowed; forwarding always picks the youngest match.
- Drain (dequeue the oldest entry into the array at the edge; head increments):
  - Occurs when the buffer is non-empty and MemRead_M=0.
  - Conditions: (a) MemWrite_M=0 (idle cycle); (b) fence=1; (c) wb_full=1.
  - At most one drain per cycle, because the array has a single port.
- Full with a store arriving: condition (c) applies, so the drain and the enqueue happen in the same edge and wb_count stays at WB_DEPTH. No store is ever dropped.
- Full with a load: no drain that cycle; the buffer stays full; the load is served by forwarding or from the array.
- Non-full store: enqueue only; wb_count increments.
- Store while fence=1 and non-empty: enqueue and drain together; wb_count is unchanged.
- Simultaneous MemRead_M and MemWrite_M: protocol error.
  - The load is serviced; the store is discarded.
  - No drain that cycle; acc_err=1 in the next cycle.
- Misaligned access (read or write): no enqueue and no array effect. Drain rules still apply as if the access were a load when MemRead_M=1, or idle when only MemWrite_M=1. acc_err=1 in the next cycle.
- acc_err is high for exactly one cycle per offending cycle; back-to-back errors keep it high continuously.
- Pointer wrap: head and tail wrap modulo WB_DEPTH. wb_count is the only full/empty source of truth and is never derived from the pointers alone.
- Reset asserted mid-drain: all buffered stores are lost and pointers clear immediately. Array words already drained keep their values.

Test Plan:
1. Reset, then sw 0x00000010 <- 0xDEADBEEF with a load asserted the next cycle at the same address. Required: ReadData_M = 0xDEADBEEF (forwarded), wb_count = 1. After one idle cycle: wb_count = 0 and the load still returns 0xDEADBEEF from the array.
2. Four stores to 0x0, 0x4, 0x8, 0xC, each followed by a load to 0x100. Required: wb_full = 1 after the 4th store. A 5th store to 0x10 keeps wb_count = 4 and drains the 0x0 entry. Loads of 0x0 and 0x10 return the stored data.
3. Stores 0x20 <- 1 then 0x20 <- 2 back-to-back, then an immediate load of 0x20. Required: ReadData_M = 2. After a full drain, array[8] = 2.
4. Load to 0x22. Required: ReadData_M = 0, acc_err = 1 for exactly one cycle, wb_count unchanged.
5. MemRead_M = MemWrite_M = 1 to 0x30 with data 0x55. Required: the store is discarded, acc_err pulses, and a subsequent load of 0x30 returns the prior contents.
6. With 3 entries buffered, hold fence = 1 under a continuous load stream, then release the loads. Required: no drain while loads are active; wb_count falls 3 -> 0 over three cycles. Assert RST mid-drain: wb_count = 0 and wb_empty = 1 asynchronously.
